// File: rtl/io_input_stage.sv
// Board input stage: 2-flop synchronizer, per-bit debounce, and optional sticky
// rising-edge flags with read-to-clear and irq (enabled by `define IO_EDGE_CAPTURE_EN).
module io_input_stage #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pins,
  input  logic        rd_strobe,
  output logic [31:0] entradas,
  output logic        irq
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  logic [15:0]      r_s1;
  logic [15:0]      r_s2;
  logic [15:0]      r_stable;
  logic [CNT_W-1:0] r_cnt [16];

  logic [15:0]      w_stable_nxt;
  logic [CNT_W-1:0] w_cnt_nxt [16];

  // The counter runs only while s2 disagrees with the stable level; any return
  // to the stable value restarts it from zero.
  always_comb begin
    w_stable_nxt = r_stable;
    for (int i = 0; i < 16; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_s2[i] != r_stable[i]) begin
        if (r_cnt[i] == LP_LAST) begin
          w_stable_nxt[i] = r_s2[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + LP_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_stable <= '0;
      for (int i = 0; i < 16; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1     <= pins;
      r_s2     <= r_s1;
      r_stable <= w_stable_nxt;
      for (int i = 0; i < 16; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

`ifdef IO_EDGE_CAPTURE_EN
  logic [15:0] r_flags;
  logic [15:0] w_rise;

  assign w_rise = w_stable_nxt & ~r_stable;

  // A rise on the same edge as a read wins for that bit only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
    end else begin
      r_flags <= (rd_strobe ? 16'h0000 : r_flags) | w_rise;
    end
  end

  assign entradas = {r_flags, r_stable};
  assign irq      = |r_flags;
`else
  logic w_unused_rd;
  assign w_unused_rd = rd_strobe;
  assign entradas    = {16'h0000, r_stable};
  assign irq         = 1'b0;
`endif

endmodule

// File: tb/tb_io_input_stage.sv
// Directed bench for io_input_stage (DB_CYCLES=4); expectations adapt to whether
// IO_EDGE_CAPTURE_EN is defined for the build.
module tb_io_input_stage;

`ifdef IO_EDGE_CAPTURE_EN
  localparam logic EDGE_EN = 1'b1;
`else
  localparam logic EDGE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pins = '0;
  logic        rd_strobe = 1'b0;
  logic [31:0] entradas;
  logic        irq;

  int n_pass  = 0;
  int n_total = 0;

  io_input_stage #(.DB_CYCLES(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .pins      (pins),
    .rd_strobe (rd_strobe),
    .entradas  (entradas),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [15:0] flags, input logic [15:0] lv);
    return {(EDGE_EN ? flags : 16'h0000), lv};
  endfunction

  function automatic logic exp_irq(input logic [15:0] flags);
    return EDGE_EN & (|flags);
  endfunction

  task automatic do_reset;
    rst = 1'b1; pins = '0; rd_strobe = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; pins = 16'hFFFF; rd_strobe = 1'b1;
    tick(3);
    rd_strobe = 1'b0;
    n_total++;
    if (entradas !== 32'h0) $display("FAIL reset_entradas: got %h want %h", entradas, 32'h0);
    else n_pass++;
    n_total++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq);
    else n_pass++;
  endtask

  // Pins held high through reset: output appears 6 edges after release.
  task automatic test_release_latency;
    rst = 1'b0;
    tick(5);
    n_total++;
    if (entradas !== 32'h0) $display("FAIL release_early: got %h want %h", entradas, 32'h0);
    else n_pass++;
    tick(1);
    n_total++;
    if (entradas !== exp_word(16'hFFFF, 16'hFFFF))
      $display("FAIL release_6edges: got %h want %h", entradas, exp_word(16'hFFFF, 16'hFFFF));
    else n_pass++;
    rd_strobe = 1'b1;
    tick(1);
    rd_strobe = 1'b0;
    n_total++;
    if (entradas !== 32'h0000_FFFF || irq !== 1'b0)
      $display("FAIL rd_all_ones: got %h/%b want %h/0", entradas, irq, 32'h0000_FFFF);
    else n_pass++;
  endtask

  task automatic test_single_bit;
    do_reset();
    pins = 16'h0001;
    tick(5);
    n_total++;
    if (entradas !== 32'h0) $display("FAIL single_early: got %h want %h", entradas, 32'h0);
    else n_pass++;
    tick(1);
    n_total++;
    if (entradas !== exp_word(16'h0001, 16'h0001))
      $display("FAIL single_6edges: got %h want %h", entradas, exp_word(16'h0001, 16'h0001));
    else n_pass++;
    n_total++;
    if (irq !== exp_irq(16'h0001)) $display("FAIL single_irq: got %b want %b", irq, exp_irq(16'h0001));
    else n_pass++;
  endtask

  task automatic test_read_clear;
    rd_strobe = 1'b1;
    tick(1);
    rd_strobe = 1'b0;
    n_total++;
    if (entradas !== 32'h0000_0001) $display("FAIL read_clear: got %h want %h", entradas, 32'h0000_0001);
    else n_pass++;
    n_total++;
    if (irq !== 1'b0) $display("FAIL read_clear_irq: got %b want 0", irq);
    else n_pass++;
  endtask

  task automatic test_glitch;
    logic bad;
    do_reset();
    bad = 1'b0;
    pins = 16'h0008;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      if (entradas[3] !== 1'b0 || entradas[19] !== 1'b0) bad = 1'b1;
    end
    pins = 16'h0000;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (entradas[3] !== 1'b0 || entradas[19] !== 1'b0) bad = 1'b1;
    end
    n_total++;
    if (bad) $display("FAIL glitch_3cyc: got entradas %h want bits 3/19 low", entradas);
    else n_pass++;
  endtask

  task automatic test_set_wins;
    do_reset();
    pins = 16'h0001;
    tick(6);
    pins = 16'h0021;
    tick(5);
    rd_strobe = 1'b1;
    tick(1);
    rd_strobe = 1'b0;
    n_total++;
    if (entradas !== exp_word(16'h0020, 16'h0021))
      $display("FAIL set_wins: got %h want %h", entradas, exp_word(16'h0020, 16'h0021));
    else n_pass++;
    n_total++;
    if (irq !== exp_irq(16'h0020)) $display("FAIL set_wins_irq: got %b want %b", irq, exp_irq(16'h0020));
    else n_pass++;
  endtask

  // Falling edge leaves flags alone; a second rise keeps the flag at 1.
  task automatic test_sticky;
    pins = 16'h0001;
    tick(6);
    n_total++;
    if (entradas !== exp_word(16'h0020, 16'h0001))
      $display("FAIL fall_keeps_flag: got %h want %h", entradas, exp_word(16'h0020, 16'h0001));
    else n_pass++;
    pins = 16'h0021;
    tick(6);
    n_total++;
    if (entradas !== exp_word(16'h0020, 16'h0021))
      $display("FAIL sticky_rise: got %h want %h", entradas, exp_word(16'h0020, 16'h0021));
    else n_pass++;
    rd_strobe = 1'b1;
    tick(1);
    rd_strobe = 1'b0;
    n_total++;
    if (entradas !== 32'h0000_0021 || irq !== 1'b0)
      $display("FAIL sticky_clear: got %h/%b want %h/0", entradas, irq, 32'h0000_0021);
    else n_pass++;
  endtask

  task automatic test_multi_bit;
    do_reset();
    pins = 16'hA5C3;
    tick(6);
    n_total++;
    if (entradas !== exp_word(16'hA5C3, 16'hA5C3))
      $display("FAIL multi_bit: got %h want %h", entradas, exp_word(16'hA5C3, 16'hA5C3));
    else n_pass++;
    pins = 16'h5A3C;
    tick(6);
    n_total++;
    if (entradas !== exp_word(16'hFFFF, 16'h5A3C))
      $display("FAIL multi_toggle: got %h want %h", entradas, exp_word(16'hFFFF, 16'h5A3C));
    else n_pass++;
  endtask

  task automatic test_reset_mid_count;
    do_reset();
    pins = 16'h0080;
    tick(4);
    rst = 1'b1;
    tick(1);
    n_total++;
    if (entradas !== 32'h0 || irq !== 1'b0)
      $display("FAIL mid_reset: got %h/%b want 0/0", entradas, irq);
    else n_pass++;
    rst = 1'b0;
    tick(5);
    n_total++;
    if (entradas !== 32'h0) $display("FAIL mid_reset_early: got %h want %h", entradas, 32'h0);
    else n_pass++;
    tick(1);
    n_total++;
    if (entradas !== exp_word(16'h0080, 16'h0080))
      $display("FAIL mid_reset_fresh: got %h want %h", entradas, exp_word(16'h0080, 16'h0080));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_release_latency();
    test_single_bit();
    test_read_clear();
    test_glitch();
    test_set_wins();
    test_sticky();
    test_multi_bit();
    test_reset_mid_count();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
